// File: rtl/rv_alu2.sv
`default_nettype none
// ============================================================================
// Module   : rv_alu2
// Desc     : Execute stage. Integer ALU (barrel or serial 1-bit/cycle
//            shifter), branch/jump resolution against the fetch prediction,
//            registered result and a one-shot PC redirect.
// Revision : 1.0  initial release
// ============================================================================
module rv_alu2 #(
   parameter int IADDR_SPACE_BITS = 32,
   parameter int SHIFT_SERIAL     = 0
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_flush,
   input  logic                        i_stall,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic [31:0]                 i_op1,
   input  logic [31:0]                 i_op2,
   input  logic [3:0]                  i_alu_op,
   input  logic [2:0]                  i_funct3,
   input  logic                        i_inst_branch,
   input  logic                        i_inst_jal_jalr,
   input  logic [31:0]                 i_reg_data1,
   input  logic [31:0]                 i_reg_data2,
   input  logic [IADDR_SPACE_BITS-1:0] i_pc,
   input  logic [IADDR_SPACE_BITS-1:0] i_pc_next,
   input  logic [IADDR_SPACE_BITS-1:0] i_pc_target,
   input  logic [4:0]                  i_rd,
   input  logic                        i_reg_write,
   input  logic                        i_store,
   output logic                        o_valid,
   output logic [31:0]                 o_result,
   output logic [4:0]                  o_rd,
   output logic                        o_reg_write,
   output logic                        o_store,
   output logic                        o_pc_change,
   output logic [IADDR_SPACE_BITS-1:0] o_pc_new,
   output logic                        o_busy
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_SLT  = 4'd3;
   localparam logic [3:0] OP_SLTU = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_AND  = 4'd9;
   localparam logic [3:0] OP_PASS = 4'd10;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t                      state_q;
   logic                        valid_q;
   logic [31:0]                 result_q;
   logic [4:0]                  rd_q;
   logic                        reg_write_q;
   logic                        store_q;
   logic                        pc_pend_q;    // this instruction mispredicted
   logic                        reported_q;   // redirect already shown to fetch
   logic [IADDR_SPACE_BITS-1:0] pc_new_q;
   logic [31:0]                 shreg_q;
   logic [4:0]                  cnt_q;
   logic [3:0]                  shop_q;

   logic                        capture_d;
   logic                        go_serial_d;
   logic                        is_shift_d;
   logic [4:0]                  shamt_d;
   logic [31:0]                 alu_d;
   logic [31:0]                 result_d;
   logic                        cond_d;
   logic                        taken_d;
   logic [IADDR_SPACE_BITS-1:0] pc_plus4_d;
   logic [IADDR_SPACE_BITS-1:0] actual_d;
   logic                        mispredict_d;
   logic [31:0]                 link_d;
   logic [31:0]                 step_d;

   assign o_busy      = (state_q == S_SHIFT);
   assign o_ready     = ~o_busy & ~i_stall;
   assign capture_d   = i_valid & o_ready & ~i_flush;
   assign o_valid     = valid_q;
   assign o_result    = result_q;
   assign o_rd        = rd_q;
   assign o_reg_write = reg_write_q;
   assign o_store     = store_q;
   assign o_pc_new    = pc_new_q;
   // The redirect is visible only on the first cycle the instruction is live.
   assign o_pc_change = valid_q & pc_pend_q & ~reported_q;

   assign shamt_d    = i_op2[4:0];
   assign is_shift_d = (i_alu_op == OP_SLL) | (i_alu_op == OP_SRL) | (i_alu_op == OP_SRA);

   // Only a non-zero shift in serial mode takes the multi-cycle path.
   generate
      if (SHIFT_SERIAL != 0) begin : g_serial
         assign go_serial_d = is_shift_d & (shamt_d != 5'd0);
      end else begin : g_barrel
         assign go_serial_d = 1'b0;
      end
   endgenerate

   // Link address pc+4, zero-extended to the 32-bit result width.
   generate
      if (IADDR_SPACE_BITS < 32) begin : g_link_ext
         assign link_d = {{(32-IADDR_SPACE_BITS){1'b0}}, pc_plus4_d};
      end else begin : g_link_full
         assign link_d = pc_plus4_d;
      end
   endgenerate

   // Single-cycle ALU result.
   always_comb begin
      alu_d = 32'd0;
      case (i_alu_op)
         OP_ADD:  alu_d = i_op1 + i_op2;
         OP_SUB:  alu_d = i_op1 - i_op2;
         OP_SLL:  alu_d = i_op1 << shamt_d;
         OP_SLT:  alu_d = {31'd0, ($signed(i_op1) < $signed(i_op2))};
         OP_SLTU: alu_d = {31'd0, (i_op1 < i_op2)};
         OP_XOR:  alu_d = i_op1 ^ i_op2;
         OP_SRL:  alu_d = i_op1 >> shamt_d;
         OP_SRA:  alu_d = $unsigned($signed(i_op1) >>> shamt_d);
         OP_OR:   alu_d = i_op1 | i_op2;
         OP_AND:  alu_d = i_op1 & i_op2;
         OP_PASS: alu_d = i_op2;
         default: alu_d = 32'd0;
      endcase
   end

   assign result_d = i_inst_jal_jalr ? link_d : alu_d;

   // Branch condition on the register compare operands.
   always_comb begin
      cond_d = 1'b0;
      case (i_funct3)
         3'b000:  cond_d = (i_reg_data1 == i_reg_data2);
         3'b001:  cond_d = (i_reg_data1 != i_reg_data2);
         3'b100:  cond_d = ($signed(i_reg_data1) <  $signed(i_reg_data2));
         3'b101:  cond_d = ($signed(i_reg_data1) >= $signed(i_reg_data2));
         3'b110:  cond_d = (i_reg_data1 <  i_reg_data2);
         3'b111:  cond_d = (i_reg_data1 >= i_reg_data2);
         default: cond_d = 1'b0;
      endcase
   end

   assign taken_d      = i_inst_jal_jalr | (i_inst_branch & cond_d);
   assign pc_plus4_d   = i_pc + IADDR_SPACE_BITS'(4);
   assign actual_d     = taken_d ? i_pc_target : pc_plus4_d;
   assign mispredict_d = (actual_d != i_pc_next);

   // One bit of serial shift in the direction of the captured op.
   always_comb begin
      step_d = shreg_q;
      case (shop_q)
         OP_SLL:  step_d = {shreg_q[30:0], 1'b0};
         OP_SRL:  step_d = {1'b0, shreg_q[31:1]};
         OP_SRA:  step_d = {shreg_q[31], shreg_q[31:1]};
         default: step_d = shreg_q;
      endcase
   end

   // Pipeline registers and serial-shift FSM; flush outranks stall.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         valid_q     <= 1'b0;
         result_q    <= 32'd0;
         rd_q        <= 5'd0;
         reg_write_q <= 1'b0;
         store_q     <= 1'b0;
         pc_pend_q   <= 1'b0;
         reported_q  <= 1'b0;
         pc_new_q    <= '0;
         shreg_q     <= 32'd0;
         cnt_q       <= 5'd0;
         shop_q      <= 4'd0;
      end else if (i_flush) begin
         state_q     <= S_IDLE;
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         store_q     <= 1'b0;
         pc_pend_q   <= 1'b0;
         reported_q  <= 1'b0;
         cnt_q       <= 5'd0;
      end else if (i_stall) begin
         // Everything holds, except that a shown redirect is marked reported.
         if (valid_q) begin
            reported_q <= 1'b1;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (capture_d) begin
                  rd_q        <= i_rd;
                  reg_write_q <= i_reg_write;
                  store_q     <= i_store;
                  pc_pend_q   <= mispredict_d;
                  pc_new_q    <= actual_d;
                  reported_q  <= 1'b0;
                  if (go_serial_d) begin
                     state_q <= S_SHIFT;
                     shreg_q <= i_op1;
                     cnt_q   <= shamt_d;
                     shop_q  <= i_alu_op;
                     valid_q <= 1'b0;
                  end else begin
                     result_q <= result_d;
                     valid_q  <= 1'b1;
                  end
               end else begin
                  valid_q <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (cnt_q == 5'd1) begin
                  result_q <= step_d;
                  cnt_q    <= 5'd0;
                  valid_q  <= 1'b1;
                  state_q  <= S_IDLE;
               end else begin
                  shreg_q <= step_d;
                  cnt_q   <= cnt_q - 5'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/rv_alu2.md
# rv_alu2

Execute stage directly downstream of the operand-select stage (`rv_alu1`). It consumes resolved operands, the PC, the predicted next PC and the branch target. It performs the integer ALU operation (optionally with a serial 1-bit/cycle shifter), resolves branches and jumps against the prediction, and presents a registered result plus a one-shot PC-redirect to the fetch side.

## Interface
- `IADDR_SPACE_BITS`, default 32: instruction address width (≤32).
- `SHIFT_SERIAL`, default 0: 0 = single-cycle barrel shifter; 1 = serial shifter with back-pressure.
- `i_clk`  in  1  clock.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_flush`  in  1  synchronous kill (trap/redirect from later stage).
- `i_stall`  in  1  downstream hold; freezes the whole block.
- `i_valid`  in  1  upstream holds a valid instruction.
- `o_ready`  out  1  block accepts the instruction this cycle = `!busy & !i_stall`.
- `i_op1`, `i_op2`  in  32 each  operands.
- `i_alu_op`  in  4  encodings: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_OP2; 11–15 give result 0.
- `i_funct3`  in  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; others never taken.
- `i_inst_branch`, `i_inst_jal_jalr`  in  1 each  instruction class.
- `i_reg_data1`, `i_reg_data2`  in  32 each  compare operands.
- `i_pc`, `i_pc_next`, `i_pc_target`  in  `IADDR_SPACE_BITS` each  PC, predicted next PC, computed target.
- `i_rd`  in  5; `i_reg_write`  in  1; `i_store`  in  1  forwarded attributes.
- `o_valid`  out  1  result registers hold a live instruction.
- `o_result`  out  32  ALU result; for jal/jalr it is `pc+4` (zero-extended).
- `o_rd`  out  5; `o_reg_write`, `o_store`  out  1 each.
- `o_pc_change`  out  1  one-cycle redirect pulse.
- `o_pc_new`  out  `IADDR_SPACE_BITS`  redirect address.
- `o_busy`  out  1  serial shift in progress.

## Operation
- Capture happens on a clock edge with `i_valid & o_ready & !i_flush`. Operands and attributes are taken, and for non-serial ops the result is computed combinationally and registered.
- Shift amount = `op2[4:0]`. SRA sign-fills. SLT is signed, SLTU is unsigned; the result is 0/1.
- Branch resolution:
  - `taken = i_inst_jal_jalr | (i_inst_branch & cond(funct3, reg_data1, reg_data2))`.
  - `actual = taken ? i_pc_target : i_pc+4`, computed modulo 2^IADDR_SPACE_BITS.
  - Mispredict = `actual != i_pc_next`.
  - On mispredict: `o_pc_new = actual` and `o_pc_change` pulses for exactly one cycle, the first cycle the instruction is presented with `o_valid`. It is not re-asserted while `i_stall` holds the instruction; a per-instruction "reported" flag tracks this.
- Serial FSM (`SHIFT_SERIAL=1`, ops SLL/SRL/SRA):
  - IDLE: capture operands and load counter = amount.
  - If amount is 0: behave like a single-cycle op.
  - Otherwise: go to SHIFT, `o_busy=1`, `o_valid=0`. Shift 1 bit per unstalled cycle and decrement the counter.
  - When the counter reaches 0: write the result, set `o_valid=1`, return to IDLE.
  - The branch decision is captured at entry and presented at completion.
- While `!i_stall` and no capture occurs, `o_valid` drops to 0 the next cycle.
- `i_stall` freezes all registers and the FSM; outputs hold.
- `i_flush`:
  - Clears `o_valid`, `o_reg_write`, `o_store`, `o_pc_change` and `o_busy`.
  - Aborts the FSM to IDLE and blocks capture in the same cycle.
  - Flush beats stall.

## Timing
- Reset (asynchronous): all outputs 0, FSM IDLE, counter 0, `o_ready=1` once reset is released (when `!i_stall`).
- Single-cycle op: capture at edge N → `o_valid`/`o_result`/`o_pc_change` visible after edge N.
- Serial shift by k>0: capture at edge N → `o_busy` high after N through N+k-1 → result valid after edge N+k. Each stalled cycle adds one cycle.
- `o_ready` is low during SHIFT, so upstream must hold its instruction.
- Back-to-back single-cycle ops sustain 1 instruction per cycle.
- Reset asserted mid-shift: immediate return to reset values; no partial result is emitted.

## Test plan
- ADD `0x7FFFFFFF + 1` → `o_result=0x80000000` one cycle after capture. SLTU `1,0xFFFFFFFF` → 1. SLT same operands → 0. SRA `0x80000000` by 4 → `0xF8000000`.
- BEQ, regs equal, `pc=0x100`, target `0x140`, `pc_next=0x104` → one-cycle `o_pc_change`, `o_pc_new=0x140`. The same case with `pc_next=0x140` → no pulse.
- BLTU `reg1=0xFFFFFFFF, reg2=1`, predicted taken (`pc_next=target`) → not taken, `o_pc_new=pc+4`, one pulse. Holding `i_stall` 3 cycles afterwards → `o_pc_change` stays low, outputs hold.
- `SHIFT_SERIAL=1`, SLL `1` by 31:
  - `o_busy` for 31 cycles, `o_ready=0`, then `o_result=0x80000000`.
  - SLL by 0 completes in 1 cycle with no busy.
- Flush mid-shift (cycle 5 of 20) → `o_busy`/`o_valid` 0 next cycle, nothing emitted. A following ADD is accepted immediately.
- Reset asserted asynchronously while `o_valid=1` with a pending redirect → all outputs 0 without waiting for a clock edge.
